// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Single-port, byte-wide RAM arbiter shared by the fetch stage and the MEM
// stage. MEM transactions (1/2/4-byte loads and stores) always win the port
// and are serialised one byte per cycle. While a MEM transaction owns the
// port, stall_req_o tells fetch to hold and re-issue its address later. Load
// data is assembled little-endian and zero-extended.
//
// Handshake: mem_req_i is a level request. It is accepted in the first IDLE
// cycle in which it is high. The requester keeps it, with all MEM fields
// stable, until the cycle in which mem_done_o is high, and drops it on that
// clock edge. mem_done_o is a one-cycle pulse. Fetch has no handshake: a
// fetch address presented in a free cycle yields if_valid_o one cycle later.
// A fetch that collides with a MEM accept is dropped, not queued.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   if_req_i     fetch byte read request
//   if_addr_i    fetch byte address
//   if_data_o    fetched byte (combinational copy of ram_din_i)
//   if_valid_o   if_data_o holds the byte addressed last cycle
//   mem_req_i    MEM transaction request (held until mem_done_o)
//   mem_we_i     1 = store, 0 = load
//   mem_addr_i   base byte address
//   mem_len_i    00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   mem_wdata_i  store data, byte 0 in bits 7:0
//   mem_rdata_o  load data, zero-extended, valid with mem_done_o
//   mem_done_o   one-cycle completion pulse
//   stall_req_o  fetch must hold while high
//   ram_a_o      RAM address
//   ram_wr_o     RAM write enable
//   ram_dout_o   RAM write byte
//   ram_din_i    RAM read byte, valid one cycle after its address
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [7:0]        if_data_o,
    output logic              if_valid_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // State and byte counter kept together so checkers can bind to one struct.
    typedef struct packed {
        state_t     state;
        logic [2:0] cnt;
    } fsm_t;

    fsm_t              fsm_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [2:0]        n_q;

    logic              accept;
    logic              fetch_slot;
    logic [2:0]        n_dec;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        rd_idx;
    logic [31:0]       rdata_nxt;

    // Reset gates the accept so nothing reaches the RAM while rst is low.
    assign accept     = rst && mem_req_i && (fsm_q.state == IDLE);
    assign fetch_slot = ((fsm_q.state == IDLE) && !accept) || (fsm_q.state == DONE);
    assign cur_addr   = base_q + ADDR_W'(fsm_q.cnt);
    // In RD with cnt=k the RAM returns byte k-1; cnt=4 maps to lane 3.
    assign rd_idx     = fsm_q.cnt[1:0] - 2'd1;
    assign if_data_o  = ram_din_i;

    always_comb begin
        n_dec = 3'd4;
        case (mem_len_i)
            2'b00:   n_dec = 3'd1;
            2'b01:   n_dec = 3'd2;
            default: n_dec = 3'd4;
        endcase
    end

    always_comb begin
        rdata_nxt = rdata_q;
        rdata_nxt[{rd_idx, 3'b000} +: 8] = ram_din_i;
    end

    // RAM port and stall request: the first byte of a MEM transaction is
    // issued straight from the inputs in the accept cycle.
    always_comb begin
        ram_a_o     = '0;
        ram_wr_o    = 1'b0;
        ram_dout_o  = 8'h00;
        stall_req_o = 1'b0;
        case (fsm_q.state)
            IDLE: begin
                if (accept) begin
                    ram_a_o     = mem_addr_i;
                    ram_wr_o    = mem_we_i;
                    ram_dout_o  = mem_wdata_i[7:0];
                    stall_req_o = 1'b1;
                end else if (if_req_i) begin
                    ram_a_o = if_addr_i;
                end
            end
            RD: begin
                ram_a_o     = cur_addr;
                stall_req_o = 1'b1;
            end
            WR: begin
                ram_a_o     = cur_addr;
                ram_wr_o    = 1'b1;
                ram_dout_o  = wdata_q[{fsm_q.cnt[1:0], 3'b000} +: 8];
                stall_req_o = 1'b1;
            end
            DONE: begin
                if (if_req_i) begin
                    ram_a_o = if_addr_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q.state <= IDLE;
            fsm_q.cnt   <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            n_q         <= 3'd0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= 32'h0;
            if_valid_o  <= 1'b0;
        end else begin
            mem_done_o <= 1'b0;
            if_valid_o <= fetch_slot && if_req_i;
            case (fsm_q.state)
                IDLE: begin
                    if (accept) begin
                        base_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        n_q     <= n_dec;
                        rdata_q <= 32'h0;
                        if (mem_we_i) begin
                            if (n_dec > 3'd1) begin
                                fsm_q.state <= WR;
                                fsm_q.cnt   <= 3'd1;
                            end else begin
                                fsm_q.state <= DONE;
                                fsm_q.cnt   <= 3'd0;
                                mem_done_o  <= 1'b1;
                                mem_rdata_o <= 32'h0;
                            end
                        end else begin
                            fsm_q.state <= RD;
                            fsm_q.cnt   <= 3'd1;
                        end
                    end
                end
                RD: begin
                    rdata_q <= rdata_nxt;
                    if (fsm_q.cnt == n_q) begin
                        fsm_q.state <= DONE;
                        fsm_q.cnt   <= 3'd0;
                        mem_done_o  <= 1'b1;
                        mem_rdata_o <= rdata_nxt;
                    end else begin
                        fsm_q.cnt <= fsm_q.cnt + 3'd1;
                    end
                end
                WR: begin
                    if (fsm_q.cnt == (n_q - 3'd1)) begin
                        fsm_q.state <= DONE;
                        fsm_q.cnt   <= 3'd0;
                        mem_done_o  <= 1'b1;
                        mem_rdata_o <= 32'h0;
                    end else begin
                        fsm_q.cnt <= fsm_q.cnt + 3'd1;
                    end
                end
                DONE: begin
                    // mem_req_i is still high here; it is ignored this cycle.
                    fsm_q.state <= IDLE;
                    fsm_q.cnt   <= 3'd0;
                end
                default: begin
                    fsm_q.state <= IDLE;
                    fsm_q.cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl with a 4 KiB byte RAM model (address bits 11:0)
// and a scoreboard queue of expected fetch bytes and load words.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [7:0]  if_data_o;
    logic        if_valid_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stall_req_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    logic [7:0]  ram [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    logic [31:0] exp_q[$];
    int          n_vec;
    int          n_err;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_valid_o  (if_valid_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_len_i   (mem_len_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .stall_req_o (stall_req_o),
        .ram_a_o     (ram_a_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data one cycle after the address
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_wr_o) ram[ram_a_o[11:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o[11:0]];
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pre(input logic [11:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        next_cycle();
        pre_en   = 1'b0;
    endtask

    // Four consecutive fetches; word holds the expected bytes little-endian.
    task automatic fetch4(input logic [31:0] addr, input logic [31:0] word, input string tag);
        logic [31:0] e;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                if_req_i  = 1'b1;
                if_addr_i = addr + 32'(i);
                exp_q.push_back((word >> (8 * i)) & 32'h0000_00ff);
            end else begin
                if_req_i = 1'b0;
            end
            @(negedge clk);
            chk1($sformatf("%s/stall%0d", tag, i), stall_req_o, 1'b0);
            chk1($sformatf("%s/done%0d", tag, i), mem_done_o, 1'b0);
            if (i < 4) chk32($sformatf("%s/addr%0d", tag, i), ram_a_o, addr + 32'(i));
            if (i > 0) begin
                chk1($sformatf("%s/valid%0d", tag, i), if_valid_o, 1'b1);
                e = exp_q.pop_front();
                chk32($sformatf("%s/data%0d", tag, i), 32'(if_data_o), e);
            end
            next_cycle();
        end
        @(negedge clk);
        chk1({tag, "/valid_end"}, if_valid_o, 1'b0);
        next_cycle();
    endtask

    // One MEM transaction, checked cycle by cycle from accept to done.
    task automatic do_mem(input logic we, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
        int          n;
        int          dc;
        logic [31:0] e;
        n  = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        dc = we ? n : n + 1;
        exp_q.push_back(exp_rd);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_len_i   = len;
        mem_wdata_i = wdata;
        for (int k = 0; k <= dc; k++) begin
            @(negedge clk);
            chk1($sformatf("%s/stall%0d", tag, k), stall_req_o, k < dc);
            chk1($sformatf("%s/done%0d", tag, k), mem_done_o, k == dc);
            chk1($sformatf("%s/wr%0d", tag, k), ram_wr_o, we && (k < n));
            chk1($sformatf("%s/ifv%0d", tag, k), if_valid_o, 1'b0);
            if (k < n) chk32($sformatf("%s/addr%0d", tag, k), ram_a_o, addr + 32'(k));
            if (we && (k < n))
                chk32($sformatf("%s/dout%0d", tag, k), 32'(ram_dout_o), (wdata >> (8 * k)) & 32'h0000_00ff);
            if (k == dc) begin
                chk32({tag, "/done_addr"}, ram_a_o, if_req_i ? if_addr_i : 32'h0);
                e = exp_q.pop_front();
                chk32({tag, "/rdata"}, mem_rdata_o, e);
            end
            next_cycle();
        end
        mem_req_i = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk1({tag, "/done"}, mem_done_o, 1'b0);
        chk1({tag, "/stall"}, stall_req_o, 1'b0);
        next_cycle();
    endtask

    initial begin
        logic [31:0] e;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h0000_0999;
        mem_len_i   = 2'b10;
        mem_wdata_i = 32'hffff_ffff;
        pre_en      = 1'b0;
        pre_addr    = 12'h0;
        pre_data    = 8'h0;
        next_cycle();

        // Preload under reset, with a MEM store request held that must be ignored.
        pre(12'h100, 8'h13); pre(12'h101, 8'h05); pre(12'h102, 8'h00); pre(12'h103, 8'h00);
        pre(12'h200, 8'hEF); pre(12'h201, 8'hBE); pre(12'h202, 8'hAD); pre(12'h203, 8'hDE);
        pre(12'h400, 8'h00); pre(12'h401, 8'h00); pre(12'h402, 8'h00); pre(12'h403, 8'h00);
        pre(12'hFFE, 8'h11); pre(12'hFFF, 8'h22); pre(12'h000, 8'h33); pre(12'h001, 8'h44);

        @(negedge clk);
        chk1("rst/done", mem_done_o, 1'b0);
        chk32("rst/rdata", mem_rdata_o, 32'h0);
        chk1("rst/ifvalid", if_valid_o, 1'b0);
        chk1("rst/wr", ram_wr_o, 1'b0);
        chk1("rst/stall", stall_req_o, 1'b0);
        next_cycle();
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        rst       = 1'b1;
        next_cycle();

        // Fetch read: 13 05 00 00
        fetch4(32'h0000_0100, 32'h0000_0513, "fetch");

        // Word load of DEADBEEF
        do_mem(1'b0, 32'h0000_0200, 2'b10, 32'h0, 32'hDEAD_BEEF, "ld_word");
        idle_cycle("ld_word/idle");

        // Half store then byte load of the upper byte
        do_mem(1'b1, 32'h0000_0300, 2'b01, 32'h0000_1234, 32'h0, "st_half");
        idle_cycle("st_half/idle");

        // Collision: fetch and MEM in the same IDLE cycle; MEM wins and the
        // fetch, still held, is served in the DONE cycle.
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        do_mem(1'b0, 32'h0000_0301, 2'b00, 32'h0, 32'h0000_0012, "coll_ld");
        if_req_i = 1'b0;
        exp_q.push_back(32'h0000_0013);
        @(negedge clk);
        chk1("coll/ifvalid", if_valid_o, 1'b1);
        e = exp_q.pop_front();
        chk32("coll/ifdata", 32'(if_data_o), e);
        chk1("coll/done_after", mem_done_o, 1'b0);
        next_cycle();

        // Address wrap, length code 11
        do_mem(1'b0, 32'hFFFF_FFFE, 2'b11, 32'h0, 32'h4433_2211, "wrap");
        idle_cycle("wrap/idle");

        // Reset abort during the second byte of a word store
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h0000_0400;
        mem_len_i   = 2'b10;
        mem_wdata_i = 32'hA1B2_C3D4;
        @(negedge clk);
        chk1("abort/wr0", ram_wr_o, 1'b1);
        chk32("abort/dout0", 32'(ram_dout_o), 32'h0000_00D4);
        next_cycle();
        @(negedge clk);
        chk1("abort/wr1", ram_wr_o, 1'b1);
        chk32("abort/addr1", ram_a_o, 32'h0000_0401);
        #1 rst = 1'b0;
        #1;
        chk1("abort/wr_rst", ram_wr_o, 1'b0);
        chk1("abort/stall_rst", stall_req_o, 1'b0);
        chk32("abort/rdata_rst", mem_rdata_o, 32'h0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            chk1($sformatf("abort/done%0d", i), mem_done_o, 1'b0);
            chk1($sformatf("abort/wr_hold%0d", i), ram_wr_o, 1'b0);
        end
        next_cycle();
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        rst       = 1'b1;
        next_cycle();
        // Only the first byte landed before the abort.
        fetch4(32'h0000_0400, 32'h0000_00D4, "post_abort");

        chk32("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
